// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Result {Cout,SUM} is registered on entry to DONE and held until the next result.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] SUM,
   output logic             Cout
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] s_next;
   logic [CW-1:0]    cnt;
   logic             c_r;
   logic             s;
   logic             c_next;

   // Full-adder cell on the current LSBs and the running carry
   assign s      = a_sr[0] ^ b_sr[0] ^ c_r;
   assign c_next = (a_sr[0] & b_sr[0]) | (c_r & (a_sr[0] ^ b_sr[0]));

   // Sum bits enter at the MSB so the LSB-first stream lands in place
   generate
      if (WIDTH == 1) begin : g_w1
         assign s_next = s;
      end else begin : g_wn
         assign s_next = {s, s_sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         c_r   <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         SUM   <= '0;
         Cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  c_r   <= Cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               c_r  <= c_next;
               s_sr <= s_next;
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               cnt  <= cnt + CW'(1);
               // Last bit: publish the result including this edge's sum and carry
               if (cnt == CW'(WIDTH - 1)) begin
                  SUM   <= s_next;
                  Cout  <= c_next;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single full-adder cell and a carry flip-flop. It consumes one bit of each operand per clock, LSB first, and presents the registered N-bit sum and carry-out with a one-cycle done pulse. It sits upstream of the lab's full-adder datapath: it sequences operand bits and the carry through the cell, trading area for latency in the mux/adder lab chain.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 1 to 32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; SUM and Cout are valid.
- SUM  output  WIDTH  registered result, held until the next result.
- Cout  output  1  registered carry-out, held with SUM.

## Operation
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- States: IDLE, SHIFT, DONE. State encoding is free.
- Internal registers:
  - a_sr, b_sr (WIDTH): operand shift registers.
  - c_r (1): running carry.
  - s_sr (WIDTH): sum shift register.
  - cnt: bit counter, ceil(log2(WIDTH+1)) bits.
- IDLE:
  - busy=0, done=0.
  - If start=1: a_sr<=A, b_sr<=B, c_r<=Cin, cnt<=0, go to SHIFT.
  - If start=0: stay in IDLE.
- SHIFT, every edge:
  - s = a_sr[0]^b_sr[0]^c_r.
  - c_r <= (a_sr[0]&b_sr[0]) | (c_r&(a_sr[0]^b_sr[0])).
  - s_sr <= {s, s_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1.
  - cnt <= cnt+1.
- Exit from SHIFT on the edge where cnt==WIDTH-1 (the last bit):
  - SUM <= final s_sr value, including this edge's bit.
  - Cout <= this edge's carry.
  - Go to DONE.
- DONE: done=1, busy=1. Next edge goes to IDLE unconditionally.
- Arithmetic: {Cout,SUM} = A + B + Cin, exact and modulo-free at WIDTH+1 bits.
- start is ignored in SHIFT and DONE. No queuing; operand changes during SHIFT have no effect.
- SUM and Cout never change except on entry to DONE or on reset. The previous result stays visible during SHIFT.
- WIDTH=1 degenerates to a single full-adder evaluation: one SHIFT cycle.

## Timing
- Reset values:
  - Outputs: busy=0, done=0, SUM=0, Cout=0.
  - Internals: state=IDLE; all internal registers 0.
- Reset asserted mid-operation:
  - Aborts immediately and asynchronously.
  - No done pulse for the aborted operation; SUM and Cout go to 0.
- Edge numbering: the accepting edge, where start is sampled in IDLE, is edge 0.
  - busy rises after edge 0.
  - Bit i is processed on edge i+1, for i=0..WIDTH-1.
  - done is high for exactly the cycle after edge WIDTH.
  - busy falls after edge WIDTH+1.
- Latency: done is visible WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accepting edge is edge WIDTH+2, with start held high.
- start held high continuously: accepted again every WIDTH+2 cycles, using the A/B/Cin values present on each accepting edge.

## Test plan
- Reset: assert rst for 2 cycles mid-stream. busy=0, done=0, SUM=0, Cout=0 immediately, before any clock edge.
- WIDTH=8, A=0x35, B=0x4A, Cin=0, start for 1 cycle:
  - done pulses exactly 8 cycles after the accepting edge.
  - SUM=0x7F, Cout=0.
- Full ripple, WIDTH=8:
  - A=0xFF, B=0x01, Cin=0 -> SUM=0x00, Cout=1.
  - Then A=0xFF, B=0xFF, Cin=1 -> SUM=0xFF, Cout=1.
  - SUM holds 0x00 throughout the second operation's SHIFT.
- start pulsed at cycles 3 and 9 after acceptance, with A=0x11, B=0x22:
  - Both pulses are ignored.
  - Result is from the original operands; only one done pulse occurs.
- Reset asserted on cycle 4 of SHIFT:
  - No done; outputs 0.
  - A fresh op A=0x80, B=0x80, Cin=0 then yields SUM=0x00, Cout=1.
- WIDTH=1, all 8 {A,B,Cin} combinations:
  - {Cout,SUM} match the full-adder truth table: 00,01,01,10,01,10,10,11.
  - done is 1 cycle after acceptance.
